// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if
// Handshake bundle between the fetch buffer, the immediate generator and the
// decode stage.
//   in_valid / in_ready / in_inst          : instruction offer from fetch
//   out_valid / out_ready                  : result handshake toward decode
//   out_imm / out_fmt / out_illegal / out_inst : result payload
// master: the side that offers instructions and consumes results.
// slave : the immediate generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_inst;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Two-stage immediate generator for the RV32/RV64 decode path. S1 captures
// the instruction with its decoded format and illegal flag; S2 holds the
// assembled, extended immediate with the pass-through instruction word.
// Ports:
//   clk   : single rising-edge clock
//   rst   : synchronous active-high reset (dominates flush)
//   flush : kills both stages on the next edge; blocks input this cycle
//   bus   : imm_gen_pipe_if slave (valid/ready in, valid/ready out + payload)
// Format codes on out_fmt: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm),
// 7 V (OPIVI simm5).
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter bit EN_VECTOR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_V    = 3'd7
    } fmt_e;

    typedef struct packed {
        fmt_e fmt;
        logic ill;
    } dec_t;

    // Opcode classification. Words with inst[1:0] != 2'b11 never match a
    // listed opcode, so they fall into the default (illegal) arm.
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        d.fmt = FMT_NONE;
        d.ill = 1'b0;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: d.fmt = FMT_I;
            7'b0011011: begin
                if (XLEN == 64) d.fmt = FMT_I;
                else            d.ill = 1'b1;
            end
            7'b0100011:             d.fmt = FMT_S;
            7'b1100011:             d.fmt = FMT_B;
            7'b0110111, 7'b0010111: d.fmt = FMT_U;
            7'b1101111:             d.fmt = FMT_J;
            // SYSTEM: CSR*I forms carry a 5-bit zimm, the rest are I-type
            7'b1110011:             d.fmt = inst[14] ? FMT_Z : FMT_I;
            7'b0110011, 7'b0000111, 7'b0100111: d.fmt = FMT_NONE;
            7'b0111011: begin
                if (XLEN != 64) d.ill = 1'b1;
            end
            7'b1010111: begin
                if (!EN_VECTOR)                 d.ill = 1'b1;
                else if (inst[14:12] == 3'b011) d.fmt = FMT_V;
            end
            default:                d.ill = 1'b1;
        endcase
        return d;
    endfunction

    // Every immediate fits in 32 bits already sign- or zero-extended, so the
    // per-format assembly is done at 32 bits and widened once afterwards.
    function automatic logic signed [31:0] assemble(input logic [31:0] inst,
                                                    input fmt_e        fmt);
        logic signed [31:0] v;
        case (fmt)
            FMT_I:   v = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0};
            FMT_U:   v = {inst[31:12], 12'b0};
            FMT_J:   v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0};
            FMT_Z:   v = {27'b0, inst[19:15]};
            FMT_V:   v = {{27{inst[19]}}, inst[19:15]};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // Control
    logic vld_p1_q, vld_p1_d;
    logic vld_p2_q, vld_p2_d;
    logic s2_adv;
    logic in_rdy;
    logic in_xfer;

    // S1 payload
    logic [31:0] inst_p1_q, inst_p1_d;
    fmt_e        fmt_p1_q,  fmt_p1_d;
    logic        ill_p1_q,  ill_p1_d;
    dec_t        dec_in;

    // S2 payload
    logic signed [XLEN-1:0] imm_p2_q,  imm_p2_d;
    fmt_e                   fmt_p2_q,  fmt_p2_d;
    logic                   ill_p2_q,  ill_p2_d;
    logic [31:0]            inst_p2_q, inst_p2_d;

    always_comb begin
        s2_adv  = !vld_p2_q || bus.out_ready;
        in_rdy  = (!vld_p1_q || s2_adv) && !flush && !rst;
        in_xfer = bus.in_valid && in_rdy;
    end

    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        if (flush) begin
            vld_p1_d = 1'b0;
            vld_p2_d = 1'b0;
        end else begin
            if (s2_adv) vld_p2_d = vld_p1_q;
            if (in_xfer)     vld_p1_d = 1'b1;
            else if (s2_adv) vld_p1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // ---- Stage 1 boundary: capture instruction with its decode ----
    always_comb begin
        dec_in    = decode(bus.in_inst);
        inst_p1_d = inst_p1_q;
        fmt_p1_d  = fmt_p1_q;
        ill_p1_d  = ill_p1_q;
        if (in_xfer) begin
            inst_p1_d = bus.in_inst;
            fmt_p1_d  = dec_in.fmt;
            ill_p1_d  = dec_in.ill;
        end
    end

    always_ff @(posedge clk) begin
        inst_p1_q <= inst_p1_d;
        fmt_p1_q  <= fmt_p1_d;
        ill_p1_q  <= ill_p1_d;
    end

    // ---- Stage 2 boundary: assembled immediate, held while stalled ----
    always_comb begin
        imm_p2_d  = imm_p2_q;
        fmt_p2_d  = fmt_p2_q;
        ill_p2_d  = ill_p2_q;
        inst_p2_d = inst_p2_q;
        if (s2_adv && vld_p1_q) begin
            imm_p2_d  = sext_xlen(assemble(inst_p1_q, fmt_p1_q));
            fmt_p2_d  = fmt_p1_q;
            ill_p2_d  = ill_p1_q;
            inst_p2_d = inst_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_p2_q  <= '0;
            fmt_p2_q  <= FMT_NONE;
            ill_p2_q  <= 1'b0;
            inst_p2_q <= '0;
        end else begin
            imm_p2_q  <= imm_p2_d;
            fmt_p2_q  <= fmt_p2_d;
            ill_p2_q  <= ill_p2_d;
            inst_p2_q <= inst_p2_d;
        end
    end

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = vld_p2_q;
    assign bus.out_imm     = imm_p2_q;
    assign bus.out_fmt     = fmt_p2_q;
    assign bus.out_illegal = ill_p2_q;
    assign bus.out_inst    = inst_p2_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (RV32+V, RV64+V, RV32 without V)
// share one input stream; a transaction-level model predicts handshake and
// payload for all of them every cycle.
module tb_imm_gen_pipe;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_inst   = '0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();
    imm_gen_pipe_if #(.XLEN(32)) bnv ();

    assign b32.in_valid = in_valid;  assign b32.in_inst = in_inst;  assign b32.out_ready = out_ready;
    assign b64.in_valid = in_valid;  assign b64.in_inst = in_inst;  assign b64.out_ready = out_ready;
    assign bnv.in_valid = in_valid;  assign bnv.in_inst = in_inst;  assign bnv.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .EN_VECTOR(1'b1)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .EN_VECTOR(1'b1)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));
    imm_gen_pipe #(.XLEN(32), .EN_VECTOR(1'b0)) dutnv (.clk(clk), .rst(rst), .flush(flush), .bus(bnv));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: immediate value as a plain signed integer from the field rules.
    function automatic void ref_model(input logic [31:0] w, input int xlen, input bit env,
                                      output logic [63:0] imm, output logic [2:0] fmt,
                                      output bit ill);
        longint v = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: fmt = 3'd1;
            7'h1B: if (xlen == 64) fmt = 3'd1; else ill = 1'b1;
            7'h23: fmt = 3'd2;
            7'h63: fmt = 3'd3;
            7'h37, 7'h17: fmt = 3'd4;
            7'h6F: fmt = 3'd5;
            7'h73: fmt = w[14] ? 3'd6 : 3'd1;
            7'h33, 7'h07, 7'h27: fmt = 3'd0;
            7'h3B: if (xlen != 64) ill = 1'b1;
            7'h57: if (!env) ill = 1'b1; else if (w[14:12] == 3'd3) fmt = 3'd7;
            default: ill = 1'b1;
        endcase
        if (!ill) begin
            case (fmt)
                3'd1: begin v = longint'(w[31:20]); if (w[31]) v -= 4096; end
                3'd2: begin v = longint'({w[31:25], w[11:7]}); if (w[31]) v -= 4096; end
                3'd3: begin
                    v = (longint'(w[31]) << 12) + (longint'(w[7]) << 11)
                      + (longint'(w[30:25]) << 5) + (longint'(w[11:8]) << 1);
                    if (w[31]) v -= 8192;
                end
                3'd4: begin v = longint'(w[31:12]) << 12; if (w[31]) v -= 64'sh1_0000_0000; end
                3'd5: begin
                    v = (longint'(w[31]) << 20) + (longint'(w[19:12]) << 12)
                      + (longint'(w[20]) << 11) + (longint'(w[30:21]) << 1);
                    if (w[31]) v -= 2097152;
                end
                3'd6: v = longint'(w[19:15]);
                3'd7: begin v = longint'(w[19:15]); if (w[19]) v -= 32; end
                default: v = 0;
            endcase
        end
        imm = v;
    endfunction

    // Transaction-level pipeline model: queue of accepted words, each stamped
    // with the edge count at which it was accepted.
    typedef struct {
        logic [31:0] inst;
        int          stamp;
    } ent_t;
    ent_t q[$];
    int   cyc = 0;

    function automatic bit exp_in_ready();
        return !rst && !flush && !(q.size() == 2 && !out_ready);
    endfunction

    function automatic bit exp_out_valid();
        return q.size() > 0 && q[0].stamp < cyc;
    endfunction

    always @(posedge clk) begin : model
        bit pop, push;
        pop  = exp_out_valid() && out_ready;
        push = in_valid && exp_in_ready();
        cyc++;
        if (rst || flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{in_inst, cyc});
        end
    end

    always @(negedge clk) begin : cmp
        logic [63:0] ei;
        logic [2:0]  ef;
        bit          el;
        bit          ov;
        bit          ir;
        ov = exp_out_valid();
        ir = exp_in_ready();
        check("in_ready32", b32.in_ready, ir);
        check("in_ready64", b64.in_ready, ir);
        check("in_readynv", bnv.in_ready, ir);
        check("out_valid32", b32.out_valid, ov);
        check("out_valid64", b64.out_valid, ov);
        check("out_validnv", bnv.out_valid, ov);
        if (ov) begin
            ref_model(q[0].inst, 32, 1'b1, ei, ef, el);
            check("imm32", b32.out_imm, ei[31:0]);
            check("fmt32", b32.out_fmt, ef);
            check("ill32", b32.out_illegal, el);
            check("inst32", b32.out_inst, q[0].inst);
            ref_model(q[0].inst, 64, 1'b1, ei, ef, el);
            check("imm64", b64.out_imm, ei);
            check("fmt64", b64.out_fmt, ef);
            check("ill64", b64.out_illegal, el);
            ref_model(q[0].inst, 32, 1'b0, ei, ef, el);
            check("immnv", bnv.out_imm, ei[31:0]);
            check("fmtnv", bnv.out_fmt, ef);
            check("illnv", bnv.out_illegal, el);
        end
    end

    // Capture of every result handed to the consumer, for ordering checks.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        bit          ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        bit          illnv;
    } cap_t;
    cap_t cap[$];

    always @(negedge clk) begin
        if (!rst && !flush && b32.out_valid && out_ready)
            cap.push_back('{b32.out_inst, b32.out_imm, b32.out_fmt, b32.out_illegal,
                            b64.out_imm, b64.out_fmt, bnv.out_illegal});
    end

    localparam logic [6:0] OPS [20] = '{
        7'h03, 7'h13, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
        7'h73, 7'h33, 7'h3B, 7'h07, 7'h27, 7'h57, 7'h57, 7'h00, 7'h7F, 7'h0B
    };

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 7) != 0) w[6:0] = OPS[$urandom_range(0, 19)];
        if (w[6:0] == 7'h57 && $urandom_range(0, 1) == 1) w[14:12] = 3'b011;
        return w;
    endfunction

    logic [31:0] plan6 [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7,
                               32'h0010006F, 32'h300FD073, 32'h022830D7};
    logic [31:0] exp_imm6 [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000,
                                  32'h00000800, 32'h0000001F, 32'hFFFFFFF0};
    logic [2:0]  exp_fmt6 [6] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] plan4 [6] = '{32'h800000B7, 32'h0010009B, 32'h00000000,
                               32'h0000007F, 32'h0, 32'h0};
    logic [31:0] bp [4] = '{32'h00500113, 32'h00A12223, 32'hFFC10113, 32'h004000EF};

    task automatic burst(input logic [31:0] w [6], input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_inst  = w[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] mi;
        logic [2:0]  mf;
        bit          ml;
        bit          took;
        int          k;

        // Model pins
        ref_model(32'hFFF00093, 32, 1'b1, mi, mf, ml);
        check("pin_addi_imm", mi, 64'hFFFF_FFFF_FFFF_FFFF);
        check("pin_addi_fmt", mf, 3'd1);
        ref_model(32'h800000B7, 64, 1'b1, mi, mf, ml);
        check("pin_lui64_imm", mi, 64'hFFFF_FFFF_8000_0000);
        ref_model(32'hFE000EE3, 32, 1'b1, mi, mf, ml);
        check("pin_branch_imm", mi[31:0], 32'hFFFFFFFC);
        ref_model(32'h022830D7, 32, 1'b0, mi, mf, ml);
        check("pin_novec_ill", ml, 1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", b32.out_valid, 1'b0);
        check("rst_out_imm", b32.out_imm, 32'h0);
        check("rst_out_fmt", b32.out_fmt, 3'd0);
        check("rst_out_ill", b32.out_illegal, 1'b0);
        check("rst_out_inst", b32.out_inst, 32'h0);
        check("rst_out_imm64", b64.out_imm, 64'h0);
        check("rst_in_ready_held", b32.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_in_ready_after", b32.in_ready, 1'b1);
        @(posedge clk); #1;

        // Test-plan stream, full throughput
        cap.delete();
        out_ready = 1'b1;
        burst(plan6, 6);
        check("plan6_count", cap.size(), 6);
        for (int i = 0; i < 6 && i < cap.size(); i++) begin
            check($sformatf("plan6_imm%0d", i), cap[i].imm32, exp_imm6[i]);
            check($sformatf("plan6_fmt%0d", i), cap[i].fmt32, exp_fmt6[i]);
        end
        if (cap.size() == 6) begin
            check("plan6_imm64_addi", cap[0].imm64, 64'hFFFF_FFFF_FFFF_FFFF);
            check("plan6_novec_ill", cap[5].illnv, 1'b1);
        end

        // XLEN-specific and illegal words
        cap.delete();
        burst(plan4, 4);
        check("plan4_count", cap.size(), 4);
        if (cap.size() == 4) begin
            check("lui64_imm", cap[0].imm64, 64'hFFFF_FFFF_8000_0000);
            check("lui64_fmt", cap[0].fmt64, 3'd4);
            check("addiw64_imm", cap[1].imm64, 64'h1);
            check("addiw64_fmt", cap[1].fmt64, 3'd1);
            check("addiw32_ill", cap[1].ill32, 1'b1);
            check("addiw32_imm", cap[1].imm32, 32'h0);
            check("zero_ill", cap[2].ill32, 1'b1);
            check("zero_fmt", cap[2].fmt32, 3'd0);
            check("zero_imm", cap[2].imm32, 32'h0);
            check("7f_ill", cap[3].ill32, 1'b1);
            check("7f_imm", cap[3].imm32, 32'h0);
        end

        // Backpressure: two accepted while stalled, then the rest
        cap.delete();
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (k < 4);
            in_inst  = bp[k % 4];
            #1;
            took = in_valid && b32.in_ready;
            @(posedge clk); #1;
            if (took) k++;
        end
        check("bp_accepted_stalled", k, 2);
        check("bp_in_ready_low", b32.in_ready, 1'b0);
        check("bp_head_inst", b32.out_inst, bp[0]);
        check("bp_head_imm", b32.out_imm, 32'd5);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && k < 4; c++) begin
            in_valid = 1'b1;
            in_inst  = bp[k % 4];
            #1;
            took = b32.in_ready;
            @(posedge clk); #1;
            if (took) k++;
        end
        check("bp_accepted_total", k, 4);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_count", cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++)
            check($sformatf("bp_order%0d", i), cap[i].inst, bp[i]);

        // Flush with both stages full and an input offered
        cap.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_inst  = bp[c];
            @(posedge clk); #1;
        end
        flush    = 1'b1;
        in_inst  = 32'h06400193;
        #1;
        check("flush_in_ready", b32.in_ready, 1'b0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", b32.out_valid, 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h00700213;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("flush_next_lat1", b32.out_valid, 1'b0);
        @(posedge clk); #1;
        check("flush_next_valid", b32.out_valid, 1'b1);
        check("flush_next_inst", b32.out_inst, 32'h00700213);
        check("flush_next_imm", b32.out_imm, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        check("flush_count", cap.size(), 1);

        // Reset while stalled with valid data
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_inst  = bp[2 * c];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_out_valid", b32.out_valid, 1'b0);
        check("rstmid_out_imm", b32.out_imm, 32'h0);
        check("rstmid_out_fmt", b32.out_fmt, 3'd0);
        check("rstmid_out_ill", b32.out_illegal, 1'b0);
        check("rstmid_out_inst", b32.out_inst, 32'h0);
        check("rstmid_imm64", b64.out_imm, 64'h0);
        rst = 1'b0;
        #1;
        check("rstmid_in_ready", b32.in_ready, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with stalls, flushes and occasional resets
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            if ((i / 300) % 2 == 1) out_ready = ($urandom_range(0, 3) == 0);
            else                    out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 249) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
